// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg: shared widths and one-hot source constants for the interrupt controller
package intr_ctrl_pkg;
  localparam int N_IRQ = 8;
  localparam int OVF_BIT = 0;
  localparam logic [N_IRQ-1:0] IRQ_OVF = N_IRQ'(1) << OVF_BIT;
  localparam logic [N_IRQ-1:0] IRQ_NONE = '0;
endpackage

// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: request/strobe/status bundle between the control unit (master) and intr_ctrl (slave)
interface intr_ctrl_if;
  import intr_ctrl_pkg::*;
  logic [N_IRQ-1:0] irq, s_calli, s_reti, mask_in, min_bit_s, min_bit_a, pending;
  logic mask_we, busy, spur_err;
  modport master(output irq, s_calli, s_reti, mask_we, mask_in,
                 input min_bit_s, min_bit_a, pending, busy, spur_err);
  modport slave(input irq, s_calli, s_reti, mask_we, mask_in,
                output min_bit_s, min_bit_a, pending, busy, spur_err);
endinterface

// File: rtl/intr_ctrl_lowbit_iso.sv
// lowbit_iso: isolates the lowest set bit of x_i as a one-hot y_o (zero when x_i is zero)
module lowbit_iso #(
  parameter int W = 8
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);
  assign y_o = x_i & (-x_i);
endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-latched interrupt controller with enable mask, in-service set and priority vectors
//   clk, reset : clock and synchronous active-high reset
//   bus        : intr_ctrl_if.slave (irq, s_calli, s_reti, mask_we, mask_in in;
//                min_bit_s, min_bit_a, pending, busy, spur_err out)
//   INTR_CTRL_SYNC_EN : when defined, irq crosses a 2-flop synchronizer (request latency 3 cycles)
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter logic [N_IRQ-1:0] MASK_RST = IRQ_NONE
) (
  input logic        clk,
  input logic        reset,
  intr_ctrl_if.slave bus
);
  logic [N_IRQ-1:0] pending_q, pending_d, active_q, active_d, mask_q, mask_d, irq_q, irq_s, rise;
  logic spur_q, spur_d;
`ifdef INTR_CTRL_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync2_q;
  assign irq_s = sync2_q;
`else
  assign irq_s = bus.irq;
`endif
  // bit 0 is the overflow source, raised only through s_calli
  assign rise = irq_s & ~irq_q & mask_q & ~IRQ_OVF;
  // a mask write takes effect on pending in the same cycle it is written
  assign mask_d = bus.mask_we ? bus.mask_in & ~IRQ_OVF : mask_q;
  assign pending_d = (pending_q & ~bus.s_calli & mask_d) | rise;
  assign active_d = (active_q & ~bus.s_reti) | bus.s_calli;
  assign spur_d = spur_q | (|(bus.s_reti & ~active_q));
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= IRQ_NONE;
      active_q  <= IRQ_NONE;
      mask_q    <= MASK_RST & ~IRQ_OVF;
      irq_q     <= IRQ_NONE;
      spur_q    <= 1'b0;
`ifdef INTR_CTRL_SYNC_EN
      sync1_q   <= IRQ_NONE;
      sync2_q   <= IRQ_NONE;
`endif
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
      mask_q    <= mask_d;
      irq_q     <= irq_s;
      spur_q    <= spur_d;
`ifdef INTR_CTRL_SYNC_EN
      sync1_q   <= bus.irq;
      sync2_q   <= sync1_q;
`endif
    end
  end
  lowbit_iso #(.W(N_IRQ)) u_iso_s (.x_i(pending_q), .y_o(bus.min_bit_s));
  lowbit_iso #(.W(N_IRQ)) u_iso_a (.x_i(active_q), .y_o(bus.min_bit_a));
  assign bus.pending = pending_q;
  assign bus.busy = |active_q;
  assign bus.spur_err = spur_q;
endmodule
